// File: rtl/deck_dealer_if.sv
// deck_dealer_if: request/result bundle between a deck_dealer and its consumer.
//   start, seed            : deal request (driven by master)
//   busy, setup_ready      : dealer status (driven by slave)
//   tableau_init           : 28 cards, flat, slot p at [p*CARD_SIZE +: CARD_SIZE]
//   talon_pile_init        : 24 cards, slot k = deck position 28+k
//   stock_pile_init        : always 0
//   talon_size_init        : 24 while setup_ready, else 0
//   stock_size_init        : always 0
interface deck_dealer_if #(
  parameter int CARD_SIZE = 6
);
  logic                    start;
  logic [15:0]             seed;
  logic                    busy;
  logic                    setup_ready;
  logic [28*CARD_SIZE-1:0] tableau_init;
  logic [24*CARD_SIZE-1:0] talon_pile_init;
  logic [24*CARD_SIZE-1:0] stock_pile_init;
  logic [4:0]              talon_size_init;
  logic [4:0]              stock_size_init;

  modport master (
    output start, seed,
    input  busy, setup_ready, tableau_init, talon_pile_init,
           stock_pile_init, talon_size_init, stock_size_init
  );

  modport slave (
    input  start, seed,
    output busy, setup_ready, tableau_init, talon_pile_init,
           stock_pile_init, talon_size_init, stock_size_init
  );
endinterface

// File: rtl/deck_dealer.sv
// deck_dealer: builds a 52-card deck, optionally shuffles it with an LFSR-driven
// Fisher-Yates pass, and deals it into solitaire setup form (28 tableau cards,
// 24 talon cards, empty stock).
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : deck_dealer_if.slave (start/seed in; busy, setup_ready, piles, sizes out)
//
// Card code is {suit[1:0], rank[3:0]}, rank 1..13; code 0 means an empty slot.
//
// Build option: define DECK_SHUFFLE_EN to build the SHUFFLE state. Without it the
// deal is the identity order, the seed is ignored, and setup_ready rises exactly
// 54 clocks after the start edge.
//
// state   | meaning
// IDLE    | waiting for start, piles empty
// INIT    | writing deck[i] = code(i), one entry per cycle, i = 0..51
// SHUFFLE | Fisher-Yates pass from i = 51 down to 1, rejecting r > i
// DEAL    | copying the deck into the pile outputs
// DONE    | deal valid; start here restarts from INIT
module deck_dealer #(
  parameter int          CARD_SIZE    = 6,
  parameter logic [15:0] LFSR_DEFAULT = 16'hACE1
) (
  input logic          clk,
  input logic          rst,
  deck_dealer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHUFFLE = 3'd2,
    DEAL    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                  state, state_next;
  logic [5:0]              idx;
  logic [CARD_SIZE-1:0]    deck [0:51];
  logic [28*CARD_SIZE-1:0] tableau_q;
  logic [24*CARD_SIZE-1:0] talon_q;
  logic [4:0]              talon_size_q;
  logic                    setup_ready_q;

  function automatic logic [CARD_SIZE-1:0] card_code(input logic [5:0] n);
    logic [1:0] suit;
    logic [3:0] rank;
    if (n < 6'd13) begin
      suit = 2'd0;
      rank = 4'(n + 6'd1);
    end else if (n < 6'd26) begin
      suit = 2'd1;
      rank = 4'(n - 6'd12);
    end else if (n < 6'd39) begin
      suit = 2'd2;
      rank = 4'(n - 6'd25);
    end else begin
      suit = 2'd3;
      rank = 4'(n - 6'd38);
    end
    return CARD_SIZE'({suit, rank});
  endfunction

`ifdef DECK_SHUFFLE_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [5:0]  rnd;
  logic        swap_ok;
  logic [15:0] seed_sel;

  // Fibonacci, taps 16,14,13,11 (maximal length)
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign rnd       = lfsr[5:0];
  assign swap_ok   = (rnd <= idx);
  // an all-zero LFSR would lock up, so seed 0 maps to the default
  assign seed_sel  = (bus.seed == 16'd0) ? LFSR_DEFAULT : bus.seed;
`else
  logic unused_seed;
  assign unused_seed = ^bus.seed;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = INIT;
      INIT: begin
        if (idx == 6'd51) begin
`ifdef DECK_SHUFFLE_EN
          state_next = SHUFFLE;
`else
          state_next = DEAL;
`endif
        end
      end
`ifdef DECK_SHUFFLE_EN
      SHUFFLE: if (swap_ok && idx == 6'd1) state_next = DEAL;
`endif
      DEAL: state_next = DONE;
      DONE: if (bus.start) state_next = INIT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= 6'd0;
      tableau_q     <= '0;
      talon_q       <= '0;
      talon_size_q  <= 5'd0;
      setup_ready_q <= 1'b0;
      for (int n = 0; n < 52; n++) deck[n] <= '0;
`ifdef DECK_SHUFFLE_EN
      lfsr          <= LFSR_DEFAULT;
`endif
    end else begin
      // registered from DONE so the piles are already stable when it rises
      setup_ready_q <= (state == DONE) && !bus.start;
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx <= 6'd0;
`ifdef DECK_SHUFFLE_EN
            lfsr <= seed_sel;
`endif
          end
        end
        INIT: begin
          deck[idx] <= card_code(idx);
          // leaves i = 51 for the shuffle pass
          if (idx != 6'd51) idx <= idx + 6'd1;
        end
`ifdef DECK_SHUFFLE_EN
        SHUFFLE: begin
          lfsr <= lfsr_next;
          if (swap_ok) begin
            deck[idx] <= deck[rnd];
            deck[rnd] <= deck[idx];
            idx       <= idx - 6'd1;
          end
        end
`endif
        DEAL: begin
          for (int p = 0; p < 28; p++) tableau_q[p*CARD_SIZE +: CARD_SIZE] <= deck[p];
          for (int k = 0; k < 24; k++) talon_q[k*CARD_SIZE +: CARD_SIZE] <= deck[28+k];
          talon_size_q <= 5'd24;
        end
        DONE: begin
          if (bus.start) begin
            tableau_q    <= '0;
            talon_q      <= '0;
            talon_size_q <= 5'd0;
            idx          <= 6'd0;
`ifdef DECK_SHUFFLE_EN
            lfsr <= seed_sel;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy            = (state == INIT) || (state == SHUFFLE) || (state == DEAL);
  assign bus.setup_ready     = setup_ready_q;
  assign bus.tableau_init    = tableau_q;
  assign bus.talon_pile_init = talon_q;
  assign bus.stock_pile_init = '0;
  assign bus.talon_size_init = talon_size_q;
  assign bus.stock_size_init = 5'd0;

endmodule
